bank_core_req_queue: RTL and testbench

//  Per-bank core request queue, directly downstream of the cache core-request bank selector.

---
 rtl/bank_core_req_queue_pkg.sv | 40 ++++
 rtl/bank_core_req_queue_if.sv | 40 ++++
 rtl/bank_req_fifo.sv | 52 +++++
 rtl/bank_core_req_queue.sv | 79 +++++++
 tb/tb_bank_core_req_queue.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bank_core_req_queue_pkg.sv
// Shared cache-bank definitions: word/lane widths, the queued request entry
// and small lane-mask helpers used by the request queue.
package bank_core_req_queue_pkg;

  localparam int WORD_SIZE       = 4;
  localparam int NUM_REQUESTS    = 4;
  localparam int CORE_TAG_WIDTH  = 8;
  localparam int WORD_WIDTH      = WORD_SIZE * 8;
  localparam int WORD_ADDR_WIDTH = 32 - $clog2(WORD_SIZE);
  localparam int LANE_W          = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;

  typedef logic [NUM_REQUESTS-1:0]    lane_mask_t;
  typedef logic [WORD_ADDR_WIDTH-1:0] word_addr_t;
  typedef logic [WORD_WIDTH-1:0]      word_t;
  typedef logic [WORD_SIZE-1:0]       byteen_t;
  typedef logic [CORE_TAG_WIDTH-1:0]  tag_t;
  typedef logic [LANE_W-1:0]          lane_t;

  typedef struct packed {
    lane_mask_t                           mask;
    logic                                 rw;
    logic [NUM_REQUESTS-1:0][WORD_ADDR_WIDTH-1:0] addr;
    logic [NUM_REQUESTS-1:0][WORD_WIDTH-1:0]      data;
    logic [NUM_REQUESTS-1:0][WORD_SIZE-1:0]       byteen;
    tag_t                                 tag;
  } req_entry_t;

  // Scanning from the top down leaves the lowest set index as the result.
  function automatic lane_t lowest_lane(input lane_mask_t m);
    lowest_lane = '0;
    for (int i = NUM_REQUESTS - 1; i >= 0; i--) begin
      if (m[i]) lowest_lane = LANE_W'(i);
    end
  endfunction

  function automatic logic is_single(input lane_mask_t m);
    is_single = (m != '0) && ((m & (m - NUM_REQUESTS'(1))) == '0);
  endfunction

endpackage

// File: rtl/bank_core_req_queue_if.sv
// Push-side and bank-side signals of the per-bank core request queue.
interface bank_core_req_queue_if;
  import bank_core_req_queue_pkg::*;

  logic                                         push_valid;
  logic                                         push_ready;
  lane_mask_t                                   push_mask;
  logic                                         push_rw;
  logic [NUM_REQUESTS-1:0][WORD_ADDR_WIDTH-1:0] push_addr;
  logic [NUM_REQUESTS-1:0][WORD_WIDTH-1:0]      push_data;
  logic [NUM_REQUESTS-1:0][WORD_SIZE-1:0]       push_byteen;
  tag_t                                         push_tag;

  logic       out_valid;
  logic       out_ready;
  lane_t      out_lane;
  word_addr_t out_addr;
  word_t      out_data;
  byteen_t    out_byteen;
  logic       out_rw;
  tag_t       out_tag;
  logic       out_last;
  logic       empty;
  logic       full;

  modport master (
    output push_valid, push_mask, push_rw, push_addr, push_data, push_byteen, push_tag,
    output out_ready,
    input  push_ready, out_valid, out_lane, out_addr, out_data, out_byteen, out_rw,
    input  out_tag, out_last, empty, full
  );

  modport slave (
    input  push_valid, push_mask, push_rw, push_addr, push_data, push_byteen, push_tag,
    input  out_ready,
    output push_ready, out_valid, out_lane, out_addr, out_data, out_byteen, out_rw,
    output out_tag, out_last, empty, full
  );

endinterface

// File: rtl/bank_req_fifo.sv
// Entry storage for the bank request queue: circular buffer with read/write
// pointers and an occupancy count that drives the full/empty flags.
module bank_req_fifo
  import bank_core_req_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  req_entry_t wr_data,
  input  logic       rd_en,
  output req_entry_t rd_data,
  output logic       empty,
  output logic       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage is deliberately left out of reset; only pointers and count matter.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/bank_core_req_queue.sv
// Per-bank core request queue: buffers multi-lane requests and hands their
// valid lanes to the bank pipeline one per cycle, lowest lane first.
module bank_core_req_queue
  import bank_core_req_queue_pkg::*;
#(
  parameter int REQQ_SIZE = 8
) (
  input logic                  clk,
  input logic                  reset,
  bank_core_req_queue_if.slave bus
);

  req_entry_t push_entry;
  req_entry_t head;
  lane_mask_t served;
  lane_mask_t remaining;
  logic       fifo_empty;
  logic       fifo_full;
  logic       push_fire;
  logic       out_fire;
  logic       pop;

  // An all-zero mask is never stored, so a head entry always has a lane to serve.
  assign push_fire = bus.push_valid & ~fifo_full & (|bus.push_mask);
  assign out_fire  = bus.out_valid & bus.out_ready;
  assign pop       = out_fire & bus.out_last;

  always_comb begin
    push_entry        = '0;
    push_entry.mask   = bus.push_mask;
    push_entry.rw     = bus.push_rw;
    push_entry.addr   = bus.push_addr;
    push_entry.data   = bus.push_data;
    push_entry.byteen = bus.push_byteen;
    push_entry.tag    = bus.push_tag;
  end

  bank_req_fifo #(
    .DEPTH (REQQ_SIZE)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_fire),
    .wr_data (push_entry),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      served <= '0;
    end else if (out_fire) begin
      if (bus.out_last) served <= '0;
      else              served[bus.out_lane] <= 1'b1;
    end
  end

  assign remaining = head.mask & ~served;

  // out_last is gated by out_valid so an unwritten head slot cannot raise it.
  assign bus.out_valid  = ~fifo_empty;
  assign bus.out_lane   = lowest_lane(remaining);
  assign bus.out_last   = ~fifo_empty & is_single(remaining);
  assign bus.out_addr   = head.addr[bus.out_lane];
  assign bus.out_data   = head.data[bus.out_lane];
  assign bus.out_byteen = head.byteen[bus.out_lane];
  assign bus.out_rw     = head.rw;
  assign bus.out_tag    = head.tag;
  assign bus.push_ready = ~fifo_full;
  assign bus.empty      = fifo_empty;
  assign bus.full       = fifo_full;

  push_mask_nonzero_a: assert property (
    @(posedge clk) disable iff (!reset) !(bus.push_valid && bus.push_mask == '0)
  );

endmodule

// File: tb/tb_bank_core_req_queue.sv
// Directed bench for bank_core_req_queue with a four-entry queue.
module tb_bank_core_req_queue;
  import bank_core_req_queue_pkg::*;

  logic clk;
  logic reset;
  int   totalChecks = 0;
  int   badChecks   = 0;

  bank_core_req_queue_if bus ();

  bank_core_req_queue #(
    .REQQ_SIZE (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every lane payload is a fixed function of the entry tag and lane index.
  function automatic word_addr_t laneAddr(input tag_t tag, input int lane);
    int v;
    v = 'h10000 + int'(tag) * 8 + lane;
    return WORD_ADDR_WIDTH'(v);
  endfunction

  function automatic word_t laneData(input tag_t tag, input int lane);
    logic [31:0] v;
    v = 32'hA500_0000 | {16'h0000, tag, 8'(lane)};
    return WORD_WIDTH'(v);
  endfunction

  function automatic byteen_t laneByteen(input int lane);
    return WORD_SIZE'(1 << lane);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input lane_mask_t mask, input logic rw,
                               input tag_t tag);
    bus.push_valid = valid;
    bus.push_mask  = mask;
    bus.push_rw    = rw;
    bus.push_tag   = tag;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      bus.push_addr[i]   = laneAddr(tag, i);
      bus.push_data[i]   = laneData(tag, i);
      bus.push_byteen[i] = laneByteen(i);
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic checkHead(input string name, input int lane, input logic last, input tag_t tag);
    checkOutput({name, "_valid"},  64'(bus.out_valid),  64'(1));
    checkOutput({name, "_lane"},   64'(bus.out_lane),   64'(lane));
    checkOutput({name, "_last"},   64'(bus.out_last),   64'(last));
    checkOutput({name, "_tag"},    64'(bus.out_tag),    64'(tag));
    checkOutput({name, "_addr"},   64'(bus.out_addr),   64'(laneAddr(tag, lane)));
    checkOutput({name, "_data"},   64'(bus.out_data),   64'(laneData(tag, lane)));
    checkOutput({name, "_byteen"}, 64'(bus.out_byteen), 64'(laneByteen(lane)));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    repeat (2) tick;

    checkOutput("rst_out_valid",  64'(bus.out_valid),  64'(0));
    checkOutput("rst_out_last",   64'(bus.out_last),   64'(0));
    checkOutput("rst_empty",      64'(bus.empty),      64'(1));
    checkOutput("rst_full",       64'(bus.full),       64'(0));
    checkOutput("rst_push_ready", 64'(bus.push_ready), 64'(1));
    reset = 1'b1;
    tick;

    // Three-lane entry drained at full rate
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 4'b1011, 1'b0, 8'h5A);
    tick;
    applyStimulus(1'b0, 4'b0000, 1'b0, 8'h00);
    checkHead("t1_l0", 0, 1'b0, 8'h5A);
    checkOutput("t1_rw", 64'(bus.out_rw), 64'(0));
    tick;
    checkHead("t1_l1", 1, 1'b0, 8'h5A);
    tick;
    checkHead("t1_l3", 3, 1'b1, 8'h5A);
    tick;
    checkOutput("t1_empty",     64'(bus.empty),     64'(1));
    checkOutput("t1_out_valid", 64'(bus.out_valid), 64'(0));

    // Fill to full with the bank stalled, then attempt a fifth push
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'b0001, 1'b0, 8'(i));
      tick;
    end
    checkOutput("t2_full",       64'(bus.full),       64'(1));
    checkOutput("t2_push_ready", 64'(bus.push_ready), 64'(0));
    checkOutput("t2_head_tag",   64'(bus.out_tag),    64'(0));
    applyStimulus(1'b1, 4'b0001, 1'b0, 8'h77);
    tick;
    checkOutput("t2_full_hold",  64'(bus.full),       64'(1));
    checkOutput("t2_head_hold",  64'(bus.out_tag),    64'(0));

    // Full with both sides active: the pop frees a slot for the next cycle
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 4'b0001, 1'b1, 8'h44);
    tick;
    checkOutput("t3_full_a",       64'(bus.full),       64'(0));
    checkOutput("t3_push_ready_a", 64'(bus.push_ready), 64'(1));
    checkOutput("t3_tag_a",        64'(bus.out_tag),    64'(1));
    tick;
    applyStimulus(1'b0, 4'b0000, 1'b0, 8'h00);
    checkOutput("t3_tag_b",  64'(bus.out_tag), 64'(2));
    checkOutput("t3_full_b", 64'(bus.full),    64'(0));
    tick;
    checkOutput("t3_tag_c",  64'(bus.out_tag), 64'(3));
    tick;
    checkOutput("t3_tag_d",  64'(bus.out_tag), 64'(8'h44));
    checkOutput("t3_rw_d",   64'(bus.out_rw),  64'(1));
    tick;
    checkOutput("t3_empty",  64'(bus.empty),   64'(1));

    // Stall on lane 1 of a two-lane entry
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 4'b0110, 1'b1, 8'h33);
    tick;
    applyStimulus(1'b0, 4'b0000, 1'b0, 8'h00);
    for (int s = 0; s < 3; s++) begin
      checkHead($sformatf("t4_stall%0d", s), 1, 1'b0, 8'h33);
      if (s == 2) bus.out_ready = 1'b1;
      tick;
    end
    checkHead("t4_l2", 2, 1'b1, 8'h33);
    tick;
    checkOutput("t4_empty", 64'(bus.empty), 64'(1));

    // Reset in the middle of an entry
    applyStimulus(1'b1, 4'b1011, 1'b0, 8'h66);
    tick;
    applyStimulus(1'b0, 4'b0000, 1'b0, 8'h00);
    checkHead("t5_l0", 0, 1'b0, 8'h66);
    tick;
    checkHead("t5_l1", 1, 1'b0, 8'h66);
    #1 reset = 1'b0;
    #1;
    checkOutput("t5_rst_valid",      64'(bus.out_valid),  64'(0));
    checkOutput("t5_rst_last",       64'(bus.out_last),   64'(0));
    checkOutput("t5_rst_empty",      64'(bus.empty),      64'(1));
    checkOutput("t5_rst_push_ready", 64'(bus.push_ready), 64'(1));
    tick;
    reset = 1'b1;
    applyStimulus(1'b1, 4'b1000, 1'b0, 8'h21);
    tick;
    applyStimulus(1'b0, 4'b0000, 1'b0, 8'h00);
    checkHead("t5_new", 3, 1'b1, 8'h21);
    tick;
    checkOutput("t5_empty", 64'(bus.empty), 64'(1));

    // Back-to-back single-lane pushes at one lane per cycle
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 4'(1 << (k % 4)), 1'(k % 2), 8'(8'h80 + k));
      tick;
      checkHead($sformatf("t6_k%0d", k), k % 4, 1'b1, 8'(8'h80 + k));
      checkOutput($sformatf("t6_rw%0d", k),   64'(bus.out_rw), 64'(k % 2));
      checkOutput($sformatf("t6_full%0d", k), 64'(bus.full),   64'(0));
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 8'h00);
    tick;
    checkOutput("t6_empty", 64'(bus.empty), 64'(1));

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
